// File: rtl/xor2.sv
// Bitwise XOR leaf primitive: combinational result, a registered copy and a
// saturating count of cycles in which the operands differ.
// Define XOR2_PARITY_EN to add parity_q, the registered odd parity of a ^ b.
module xor2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] diff_cnt,
  output logic             diff_sat
`ifdef XOR2_PARITY_EN
  ,
  output logic             parity_q
`endif
);

  logic diff;

  // Plain XOR so an X/Z operand bit shows up as X on the matching out bit.
  assign out  = a ^ b;
  assign diff = |out;

  assign diff_sat = (diff_cnt == {CNT_W{1'b1}});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of the order in which blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

  // Clear has priority over counting; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_cnt <= '0;
    end else if (cnt_clr) begin
      diff_cnt <= '0;
    end else if (diff && !diff_sat) begin
      diff_cnt <= diff_cnt + CNT_W'(1);
    end
  end

`ifdef XOR2_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^out;
    end
  end
`endif

endmodule

// File: tb/tb_xor2.sv
// Self-checking bench for xor2: three instances (WIDTH=1/CNT_W=8,
// WIDTH=1/CNT_W=2, WIDTH=4/CNT_W=8) checked against an arithmetic model.
module tb_xor2;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst;
  logic chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  // Instance 1: WIDTH=1, CNT_W=8
  logic       a1 = 1'b0, b1 = 1'b0, clr1 = 1'b0;
  logic       out1, q1, sat1;
  logic [7:0] cnt1;
  // Instance 2: WIDTH=1, CNT_W=2
  logic       a2 = 1'b0, b2 = 1'b0, clr2 = 1'b0;
  logic       out2, q2, sat2;
  logic [1:0] cnt2;
  // Instance 4: WIDTH=4, CNT_W=8
  logic [3:0] a4 = 4'd0, b4 = 4'd0;
  logic       clr4 = 1'b0;
  logic [3:0] out4, q4;
  logic [7:0] cnt4;
  logic       sat4;
`ifdef XOR2_PARITY_EN
  logic       par1, par2, par4;
`endif

  xor2 #(.WIDTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cnt_clr(clr1),
    .out(out1), .out_q(q1), .diff_cnt(cnt1), .diff_sat(sat1)
`ifdef XOR2_PARITY_EN
    , .parity_q(par1)
`endif
  );

  xor2 #(.WIDTH(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .cnt_clr(clr2),
    .out(out2), .out_q(q2), .diff_cnt(cnt2), .diff_sat(sat2)
`ifdef XOR2_PARITY_EN
    , .parity_q(par2)
`endif
  );

  xor2 #(.WIDTH(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cnt_clr(clr4),
    .out(out4), .out_q(q4), .diff_cnt(cnt4), .diff_sat(sat4)
`ifdef XOR2_PARITY_EN
    , .parity_q(par4)
`endif
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected register contents after each edge.
  int m_q1 = 0, m_c1 = 0, m_q2 = 0, m_c2 = 0, m_q4 = 0, m_c4 = 0, m_p4 = 0;

  function automatic int next_cnt(int c, logic clr, int diff_bits, int max);
    if (clr) return 0;
    if (diff_bits != 0 && c < max) return c + 1;
    return c;
  endfunction

  function automatic int odd_parity(int v);
    int p = 0;
    for (int i = 0; i < 32; i++) p ^= (v >> i) & 1;
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q1 = 0; m_c1 = 0; m_q2 = 0; m_c2 = 0; m_q4 = 0; m_c4 = 0; m_p4 = 0;
    end else begin
      m_q1 = int'(a1 ^ b1);
      m_c1 = next_cnt(m_c1, clr1, m_q1, 255);
      m_q2 = int'(a2 ^ b2);
      m_c2 = next_cnt(m_c2, clr2, m_q2, 3);
      m_q4 = int'(a4 ^ b4);
      m_c4 = next_cnt(m_c4, clr4, m_q4, 255);
      m_p4 = odd_parity(m_q4);
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_out1", 32'(out1), 32'(a1 ^ b1));
      check("cmp_q1", 32'(q1), m_q1);
      check("cmp_cnt1", 32'(cnt1), m_c1);
      check("cmp_sat1", 32'(sat1), 32'(m_c1 == 255));
      check("cmp_out2", 32'(out2), 32'(a2 ^ b2));
      check("cmp_q2", 32'(q2), m_q2);
      check("cmp_cnt2", 32'(cnt2), m_c2);
      check("cmp_sat2", 32'(sat2), 32'(m_c2 == 3));
      check("cmp_out4", 32'(out4), 32'(a4 ^ b4));
      check("cmp_q4", 32'(q4), m_q4);
      check("cmp_cnt4", 32'(cnt4), m_c4);
      check("cmp_sat4", 32'(sat4), 32'(m_c4 == 255));
`ifdef XOR2_PARITY_EN
      check("cmp_par1", 32'(par1), m_q1);
      check("cmp_par4", 32'(par4), m_p4);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:0] tt_a, tt_b, tt_o;
    rst = 1'b1;
    #1;
    check("rst_q1", 32'(q1), 0);
    check("rst_cnt1", 32'(cnt1), 0);
    check("rst_sat1", 32'(sat1), 0);
    check("rst_q4", 32'(q4), 0);

    // Truth table with no clock activity, while reset is held.
    tt_a = 2'b01; tt_b = 2'b00; tt_o = 2'b01;
    for (int i = 0; i < 4; i++) begin
      a1 = i[0]; b1 = i[1];
      #10;
      check("truth_table", 32'(out1), 32'(i[0] ^ i[1]));
    end
    a1 = 1'b0; b1 = 1'b1; #10;
    check("tt_01", 32'(out1), 32'(tt_o[0]));
    a1 = tt_a[0]; b1 = tt_b[0]; #10;
    check("tt_10", 32'(out1), 1);
    a1 = 1'b0; b1 = 1'b0;

    clk_en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;

    // Registered path
    a1 = 1'b1; b1 = 1'b0;
    check("q_before_edge", 32'(q1), 0);
    tick();
    check("q_after_edge_n", 32'(q1), 1);
    a1 = 1'b1; b1 = 1'b1;
    tick();
    check("q_after_edge_n1", 32'(q1), 0);
    check("cnt1_one_event", 32'(cnt1), 1);

    // Saturation on CNT_W=2
    a2 = 1'b1; b2 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("sat_seq_cnt", 32'(cnt2), (i < 3) ? i : 3);
      check("sat_seq_flag", 32'(sat2), 32'(i >= 3));
    end

    // Clear priority
    clr2 = 1'b1; a2 = 1'b0;
    tick();
    check("clr_to_zero", 32'(cnt2), 0);
    clr2 = 1'b0; a2 = 1'b1;
    tick(); tick();
    check("cnt_reaches_2", 32'(cnt2), 2);
    clr2 = 1'b1;
    tick();
    check("clr_beats_event", 32'(cnt2), 0);
    clr2 = 1'b0;
    tick();
    check("count_after_clr", 32'(cnt2), 1);
    a2 = 1'b0;

    // WIDTH=4
    a4 = 4'b1010; b4 = 4'b0110;
    #1;
    check("w4_out_comb", 32'(out4), 32'h0000000c);
    tick();
    check("w4_q", 32'(q4), 32'h0000000c);
`ifdef XOR2_PARITY_EN
    check("w4_par_even", 32'(par4), 0);
`endif
    a4 = 4'b0001; b4 = 4'b0000;
    tick();
    check("w4_q_0001", 32'(q4), 1);
`ifdef XOR2_PARITY_EN
    check("w4_par_odd", 32'(par4), 1);
`endif

    // Async reset mid-run with out_q=1 and diff_cnt=5
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
    repeat (5) tick();
    check("pre_rst_cnt5", 32'(cnt1), 5);
    check("pre_rst_q1", 32'(q1), 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_q", 32'(q1), 0);
    check("async_rst_cnt", 32'(cnt1), 0);
    check("out_in_rst", 32'(out1), 1);
    a1 = 1'b0; b1 = 1'b1;
    #1;
    check("out_tracks_in_rst", 32'(out1), 1);
    tick();
    check("q_held_in_rst", 32'(q1), 0);
    rst = 1'b0;
    tick();
    check("first_edge_after_rst", 32'(q1), 1);
    check("cnt_after_rst", 32'(cnt1), 1);

    // Randomized run, checked every cycle by the compare process
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #2;
      a1 = 1'($urandom); b1 = 1'($urandom);
      a2 = 1'($urandom_range(0, 3) != 0); b2 = 1'($urandom_range(0, 3) == 0);
      a4 = 4'($urandom); b4 = 4'($urandom);
      clr1 = ($urandom_range(0, 31) == 0);
      clr2 = ($urandom_range(0, 15) == 0);
      clr4 = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
    end

    @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor2.md
Name: xor2

Overview:
- Two-input bitwise XOR gate with a combinational output. The combinational path has zero-cycle latency.
- A registered copy of the result and a saturating "inputs differ" event counter are added for use in clocked datapaths.
- Used as a leaf primitive in arithmetic and parity logic. The combinational output must be valid without any clock activity.

Parameters:
- WIDTH, 1, bit width of a, b, out and out_q.
- CNT_W, 8, width of the difference-event counter diff_cnt.

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cnt_clr  input  1  synchronous clear of diff_cnt.
- out  output  WIDTH  combinational result, a ^ b.
- out_q  output  WIDTH  registered result.
- diff_cnt  output  CNT_W  saturating count of cycles in which out is non-zero.
- diff_sat  output  1  high when diff_cnt is at its maximum value.

Behaviour:
- out = a ^ b, bitwise, purely combinational.
  - No clock, no reset dependency.
  - Valid within the same delta as any input change, including while rst is high.
- Truth table per bit: 0,0->0; 1,0->1; 0,1->1; 1,1->0.
- X/Z on an input bit propagates as X on the corresponding out bit. No masking.
- out_q:
  - On rst high (asynchronous, no clock needed): out_q = 0.
  - Otherwise, on every rising clk edge: out_q <= a ^ b.
  - Latency is 1 cycle.
- diff_cnt:
  - On rst high (asynchronous): 0.
  - On a rising clk edge with rst low, priority is:
    1. cnt_clr=1 -> 0.
    2. Else if (a ^ b) != 0 and diff_cnt < 2^CNT_W-1 -> increment by 1.
    3. Else hold.
  - Saturates at all-ones and never wraps.
  - Simultaneous cnt_clr and a difference event: clear wins; the event is not counted.
- diff_sat = (diff_cnt == all-ones), combinational from the register.
- Reset asserted mid-operation:
  - out_q, diff_cnt and diff_sat clear immediately.
  - out continues tracking the inputs.
- Reset deassertion: the first clocked update occurs on the first rising edge with rst low.
- No internal state other than out_q and diff_cnt. No handshake.

Optional Feature:
- Macro XOR2_PARITY_EN.
- When defined:
  - Adds an output port parity_q (1 bit).
  - On rst high (asynchronous): parity_q = 0.
  - Otherwise, on each rising clk edge: parity_q <= reduction-XOR of (a ^ b), i.e. odd parity across all WIDTH result bits.
  - With WIDTH=1, parity_q equals out_q.
- When undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Combinational truth table (WIDTH=1), no clock toggling, 10 ns steps: (a,b)=(0,0)->out=0; (1,0)->1; (0,1)->1; (1,1)->0.
- Registered path: rst high then low; a=1,b=0 applied before edge N.
  - out_q=0 before edge N, out_q=1 after edge N.
  - Then a=b=1: out_q=0 after edge N+1.
- Async reset mid-run:
  - With out_q=1 and diff_cnt=5, assert rst between clock edges: out_q=0 and diff_cnt=0 immediately.
  - out still equals a ^ b while rst is high.
- Counter saturation (CNT_W=2): hold a=1,b=0 for 5 edges -> diff_cnt sequence 1,2,3,3,3; diff_sat=1 from the third edge.
- Clear priority: diff_cnt=2, cnt_clr=1 with a=1,b=0 on one edge -> diff_cnt=0. Next edge with cnt_clr=0 -> diff_cnt=1.
- WIDTH=4 with XOR2_PARITY_EN defined:
  - a=4'b1010, b=4'b0110 -> out=4'b1100 immediately; after one edge out_q=4'b1100, parity_q=0.
  - a=4'b0001, b=0 -> parity_q=1 after the next edge.
